// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default divisor width and iteration-counter sizing.
package div_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit beyond the iteration count keeps the terminal value representable.
    function automatic int cnt_width(input int dw);
        return $clog2(2 * dw) + 1;
    endfunction

    localparam int CNT_W_DEF = $clog2(2 * DW_DEF) + 1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {partial remainder, dividend} left by one,
// conditionally subtract the divisor and shift the quotient bit in at the LSB.
module div_step
    import div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0]     prem,
    input  logic [2*DW-1:0] dvd,
    input  logic [DW-1:0]   dsr,
    output logic [DW:0]     prem_next,
    output logic [2*DW-1:0] dvd_next
);

    logic [DW:0] shifted_s;
    logic        ge_s;

    // Compare/subtract; a set top bit of prem already exceeds any divisor.
    always_comb begin
        shifted_s = {prem[DW-1:0], dvd[2*DW-1]};
        ge_s      = prem[DW] | (shifted_s >= {1'b0, dsr});
        if (ge_s) begin
            prem_next = shifted_s - {1'b0, dsr};
        end else begin
            prem_next = shifted_s;
        end
        dvd_next = {dvd[2*DW-2:0], ge_s};
    end

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential 2*DW / DW unsigned divider: one restoring step per clock in CALC,
// with registered results, a one-cycle done pulse and divide-by-zero flagging.
module seq_div_16by8
    import div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    localparam int CNT_W = cnt_width(DW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * DW - 1);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DW:0]       prem_r, prem_s;
    logic [2*DW-1:0]   dvd_r, dvd_s;
    logic [DW-1:0]     dsr_r, dsr_s;
    logic [2*DW-1:0]   quotient_r, quotient_s;
    logic [DW-1:0]     remainder_r, remainder_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              div_zero_r, div_zero_s;
    logic [DW:0]       step_prem_s;
    logic [2*DW-1:0]   step_dvd_s;

    div_step #(.DW(DW)) u_step (
        .prem      (prem_r),
        .dvd       (dvd_r),
        .dsr       (dsr_r),
        .prem_next (step_prem_s),
        .dvd_next  (step_dvd_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        prem_s      = prem_r;
        dvd_s       = dvd_r;
        dsr_s       = dsr_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        div_zero_s  = div_zero_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    cnt_s  = '0;
                    prem_s = '0;
                    if (divisor == {DW{1'b0}}) begin
                        // Divide by zero skips iteration and reports at once.
                        state_s     = DONE;
                        quotient_s  = '1;
                        remainder_s = dividend[DW-1:0];
                        div_zero_s  = 1'b1;
                        done_s      = 1'b1;
                    end else begin
                        state_s    = CALC;
                        dvd_s      = dividend;
                        dsr_s      = divisor;
                        div_zero_s = 1'b0;
                        busy_s     = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                prem_s = step_prem_s;
                dvd_s  = step_dvd_s;
                cnt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    state_s     = DONE;
                    quotient_s  = step_dvd_s;
                    remainder_s = step_prem_s[DW-1:0];
                    done_s      = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            prem_r      <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            div_zero_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            prem_r      <= prem_s;
            dvd_r       <= dvd_s;
            dsr_r       <= dsr_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            div_zero_r  <= div_zero_s;
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed, table-driven bench for seq_div_16by8 with hand-written sequences
// for ignored starts, back-to-back operation, mid-calculation reset and a round trip.
module tb_seq_div_16by8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div_16by8 #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dsr;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one start, then count edges after the accepting edge until done.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int lat, bcnt, seen;
        logic [15:0] p;
        int bvals[17];

        vecs[0]  = '{16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0, 16};
        vecs[1]  = '{16'd1000, 8'd7,  16'd142,  8'd6,  1'b0, 16};
        vecs[2]  = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 0};
        vecs[3]  = '{16'd100,  8'd10, 16'd10,   8'd0,  1'b0, 16};
        vecs[4]  = '{16'd0,    8'd5,  16'd0,    8'd0,  1'b0, 16};
        vecs[5]  = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16};
        vecs[6]  = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16};
        vecs[7]  = '{16'hFFFF, 8'h02, 16'h7FFF, 8'h01, 1'b0, 16};
        vecs[8]  = '{16'h0005, 8'hC8, 16'h0000, 8'h05, 1'b0, 16};
        vecs[9]  = '{16'h0000, 8'h00, 16'hFFFF, 8'h00, 1'b1, 0};
        vecs[10] = '{16'hFFFF, 8'h00, 16'hFFFF, 8'hFF, 1'b1, 0};
        vecs[11] = '{16'h8000, 8'h03, 16'h2AAA, 8'h02, 1'b0, 16};

        rst_n = 1'b0; start = 1'b0; dividend = 16'h0; divisor = 8'h0;
        #12;
        check("rst_quotient", quotient, 16'h0);
        check("rst_remainder", remainder, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].dvd, vecs[i].dsr, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("v%0d_div_zero", i), div_zero, vecs[i].dz);
            check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].dz ? 0 : 16);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), done, 1'b0);
            check($sformatf("v%0d_q_held", i), quotient, vecs[i].q);
            check($sformatf("v%0d_r_held", i), remainder, vecs[i].r);
        end

        // Start during CALC is ignored; operand changes during CALC are ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'hA6EF; divisor = 8'hE7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        start = 1'b1; dividend = 16'h1234; divisor = 8'h12;
        @(posedge clk); #1; lat++;
        start = 1'b0; dividend = 16'h5555; divisor = 8'h01;
        check("ign_busy", busy, 1'b1);
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ign_latency", lat, 16);
        check("ign_quotient", quotient, 16'h00B9);
        check("ign_remainder", remainder, 8'h00);
        check("ign_div_zero", div_zero, 1'b0);
        repeat (2) @(posedge clk);

        // start held high: the next division is accepted in DONE.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        seen = 0;
        while (!done && seen < 40) begin @(posedge clk); #1; seen++; end
        check("b2b_first_latency", seen, 17);
        @(posedge clk); #1;
        lat = 1;
        check("b2b_busy_after_done", busy, 1'b1);
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        start = 1'b0;
        check("b2b_done_spacing", lat, 17);
        check("b2b_quotient", quotient, 16'd142);
        check("b2b_remainder", remainder, 8'd6);
        repeat (2) @(posedge clk);

        // Reset during CALC aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 16'h0);
        check("abort_remainder", remainder, 8'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_div_zero", div_zero, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (done || busy) seen++; end
        check("abort_no_done", seen, 0);
        run_div(16'd100, 8'd10, lat, bcnt);
        check("after_rst_latency", lat, 16);
        check("after_rst_quotient", quotient, 16'd10);
        check("after_rst_remainder", remainder, 8'd0);

        // Round trip: (a*b)/b must give a with zero remainder.
        for (int k = 0; k < 16; k++) bvals[k] = 1 + 16 * k;
        bvals[16] = 255;
        for (int a = 0; a < 256; a += 17) begin
            for (int k = 0; k < 17; k++) begin
                p = 16'(a * bvals[k]);
                run_div(p, 8'(bvals[k]), lat, bcnt);
                check($sformatf("rt_q_%0d_%0d", a, bvals[k]), quotient, 16'(a));
                check($sformatf("rt_r_%0d_%0d", a, bvals[k]), remainder, 8'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
